// File: rtl/blink_cmd_rx_if.sv
// Bundle of the serial input and configuration outputs of the blink command receiver.
// The receiver takes the slave side; whoever drives rx takes the master side.
interface blink_cmd_rx_if;
  logic       rx;
  logic [7:0] pattern;
  logic [7:0] on_time;
  logic [7:0] off_time;
  logic       enable;
  logic       cfg_valid;
  logic       frame_err;

  modport master (
    output rx,
    input  pattern, on_time, off_time, enable, cfg_valid, frame_err
  );

  modport slave (
    input  rx,
    output pattern, on_time, off_time, enable, cfg_valid, frame_err
  );
endinterface

// File: rtl/blink_cmd_rx.sv
// UART 8N1 command receiver for the LED blinker: byte receiver, 4-byte frame parser
// (A5, CMD, DATA, CMD^DATA) and the blink configuration registers.
//
// state    | meaning
// S_IDLE   | waiting for a low level on the synchronised rx
// S_START  | timing to mid start bit, rejecting glitches
// S_DATA   | sampling 8 data bits, LSB first
// S_STOP   | sampling the stop bit
// P_SYNC   | hunting for the A5 sync byte
// P_CMD    | expecting the command byte
// P_DATA   | expecting the data byte
// P_CSUM   | expecting the checksum byte
module blink_cmd_rx #(
  parameter int CLK_FREQ      = 25_000_000,
  parameter int BAUD          = 115200,
  parameter int FRAME_TIMEOUT = CLK_FREQ / 10
) (
  input logic           clk,
  input logic           rst,
  blink_cmd_rx_if.slave bus
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam int TO_W         = $clog2(FRAME_TIMEOUT + 1);

  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [TO_W-1:0]  TO_LOAD   = TO_W'(FRAME_TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [1:0] P_SYNC = 2'd0;
  localparam logic [1:0] P_CMD  = 2'd1;
  localparam logic [1:0] P_DATA = 2'd2;
  localparam logic [1:0] P_CSUM = 2'd3;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  logic             r_rx_meta;
  logic             r_rx_sync;
  logic [1:0]       r_rx_state;
  logic [CNT_W-1:0] r_clk_cnt;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic             r_byte_valid;
  logic             r_stop_err;

  logic [1:0]       r_p_state;
  logic [7:0]       r_cmd;
  logic [7:0]       r_data;
  logic [TO_W-1:0]  r_to_cnt;

  logic [7:0]       r_pattern;
  logic [7:0]       r_on_time;
  logic [7:0]       r_off_time;
  logic             r_enable;
  logic             r_cfg_valid;
  logic             r_frame_err;

  logic             w_csum_ok;
  logic             w_cmd_ok;
  logic             w_timeout;

  // Byte receiver; r_shift holds the completed byte while r_byte_valid is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta    <= 1'b1;
      r_rx_sync    <= 1'b1;
      r_rx_state   <= S_IDLE;
      r_clk_cnt    <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_byte_valid <= 1'b0;
      r_stop_err   <= 1'b0;
    end else begin
      r_rx_meta    <= bus.rx;
      r_rx_sync    <= r_rx_meta;
      r_byte_valid <= 1'b0;
      r_stop_err   <= 1'b0;
      case (r_rx_state)
        S_IDLE: begin
          if (!r_rx_sync) begin
            r_rx_state <= S_START;
            r_clk_cnt  <= HALF_LOAD;
            r_bit_cnt  <= '0;
          end
        end
        S_START: begin
          if (r_clk_cnt == '0) begin
            if (r_rx_sync) begin
              r_rx_state <= S_IDLE;
            end else begin
              r_rx_state <= S_DATA;
              r_clk_cnt  <= BIT_LOAD;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (r_clk_cnt == '0) begin
            r_shift   <= {r_rx_sync, r_shift[7:1]};
            r_clk_cnt <= BIT_LOAD;
            if (r_bit_cnt == 3'd7) begin
              r_rx_state <= S_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt - 1'b1;
          end
        end
        S_STOP: begin
          if (r_clk_cnt == '0) begin
            r_byte_valid <= r_rx_sync;
            r_stop_err   <= ~r_rx_sync;
            r_rx_state   <= S_IDLE;
          end else begin
            r_clk_cnt <= r_clk_cnt - 1'b1;
          end
        end
        default: r_rx_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_csum_ok = (r_shift == (r_cmd ^ r_data));
    case (r_cmd)
      8'h01:   w_cmd_ok = 1'b1;
      8'h02:   w_cmd_ok = (r_data != 8'h00);
      8'h03:   w_cmd_ok = (r_data != 8'h00);
      8'h04:   w_cmd_ok = 1'b1;
      default: w_cmd_ok = 1'b0;
    endcase
    w_timeout = (r_p_state != P_SYNC) && !r_byte_valid && (r_to_cnt == '0);
  end

  // Frame parser and configuration registers. Stop and timeout errors never
  // coincide with a byte, so cfg_valid and frame_err stay mutually exclusive.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p_state   <= P_SYNC;
      r_cmd       <= '0;
      r_data      <= '0;
      r_to_cnt    <= '0;
      r_pattern   <= 8'hFF;
      r_on_time   <= 8'd5;
      r_off_time  <= 8'd20;
      r_enable    <= 1'b1;
      r_cfg_valid <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_cfg_valid <= 1'b0;
      r_frame_err <= 1'b0;
      if (r_stop_err) begin
        r_p_state   <= P_SYNC;
        r_frame_err <= 1'b1;
      end else if (r_byte_valid) begin
        r_to_cnt <= TO_LOAD;
        case (r_p_state)
          P_SYNC: if (r_shift == SYNC_BYTE) r_p_state <= P_CMD;
          P_CMD: begin
            r_cmd     <= r_shift;
            r_p_state <= P_DATA;
          end
          P_DATA: begin
            r_data    <= r_shift;
            r_p_state <= P_CSUM;
          end
          default: begin
            r_p_state <= P_SYNC;
            if (w_csum_ok && w_cmd_ok) begin
              r_cfg_valid <= 1'b1;
              if (r_cmd == 8'h01) r_pattern  <= r_data;
              if (r_cmd == 8'h02) r_on_time  <= r_data;
              if (r_cmd == 8'h03) r_off_time <= r_data;
              if (r_cmd == 8'h04) r_enable   <= r_data[0];
            end else begin
              r_frame_err <= 1'b1;
            end
          end
        endcase
      end else if (w_timeout) begin
        r_p_state   <= P_SYNC;
        r_frame_err <= 1'b1;
      end else if (r_p_state != P_SYNC) begin
        r_to_cnt <= r_to_cnt - 1'b1;
      end
    end
  end

  assign bus.pattern   = r_pattern;
  assign bus.on_time   = r_on_time;
  assign bus.off_time  = r_off_time;
  assign bus.enable    = r_enable;
  assign bus.cfg_valid = r_cfg_valid;
  assign bus.frame_err = r_frame_err;

endmodule

// File: tb/tb_blink_cmd_rx.sv
// Self-checking bench for blink_cmd_rx: table of command frames plus directed
// sequences for timeout, bad stop bit, start glitch and mid-frame reset.
module tb_blink_cmd_rx;
  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 100_000;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int FT       = 3000;

  logic clk;
  logic rst;
  blink_cmd_rx_if bus();

  blink_cmd_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FRAME_TIMEOUT(FT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] data;
    logic [7:0] csum;
    logic [7:0] pat;
    logic [7:0] on_t;
    logic [7:0] off_t;
    logic       en;
    logic       ok;
  } vec_t;

  vec_t vecs[11];

  int n_cmp = 0;
  int n_bad = 0;

  int cfg_cnt  = 0;
  int err_cnt  = 0;
  int both_cnt = 0;
  logic [7:0] snap_pat;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.cfg_valid) begin
        cfg_cnt++;
        snap_pat = bus.pattern;
      end
      if (bus.frame_err) err_cnt++;
      if (bus.cfg_valid && bus.frame_err) both_cnt++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    bus.rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    bus.rx = stop;
    repeat (CPB) @(posedge clk);
    bus.rx = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] data,
                            input logic [7:0] csum);
    send_byte(8'hA5, 1'b1);
    send_byte(cmd, 1'b1);
    send_byte(data, 1'b1);
    send_byte(csum, 1'b1);
  endtask

  task automatic check_regs(input string tag, input logic [7:0] pat, input logic [7:0] on_t,
                            input logic [7:0] off_t, input logic en);
    check({tag, "_pattern"}, int'(bus.pattern), int'(pat));
    check({tag, "_on_time"}, int'(bus.on_time), int'(on_t));
    check({tag, "_off_time"}, int'(bus.off_time), int'(off_t));
    check({tag, "_enable"}, int'(bus.enable), int'(en));
  endtask

  initial begin
    int c0, e0, k;
    logic found;

    vecs[0]  = '{8'h01, 8'h3C, 8'h3D, 8'h3C, 8'h05, 8'h14, 1'b1, 1'b1};
    vecs[1]  = '{8'h02, 8'h0A, 8'h08, 8'h3C, 8'h0A, 8'h14, 1'b1, 1'b1};
    vecs[2]  = '{8'h03, 8'h00, 8'h03, 8'h3C, 8'h0A, 8'h14, 1'b1, 1'b0};
    vecs[3]  = '{8'h01, 8'h55, 8'h00, 8'h3C, 8'h0A, 8'h14, 1'b1, 1'b0};
    vecs[4]  = '{8'h04, 8'h00, 8'h04, 8'h3C, 8'h0A, 8'h14, 1'b0, 1'b1};
    vecs[5]  = '{8'h01, 8'h3C, 8'h3D, 8'h3C, 8'h0A, 8'h14, 1'b0, 1'b1};
    vecs[6]  = '{8'h05, 8'h11, 8'h14, 8'h3C, 8'h0A, 8'h14, 1'b0, 1'b0};
    vecs[7]  = '{8'h02, 8'h00, 8'h02, 8'h3C, 8'h0A, 8'h14, 1'b0, 1'b0};
    vecs[8]  = '{8'h03, 8'hFF, 8'hFC, 8'h3C, 8'h0A, 8'hFF, 1'b0, 1'b1};
    vecs[9]  = '{8'h04, 8'h01, 8'h05, 8'h3C, 8'h0A, 8'hFF, 1'b1, 1'b1};
    vecs[10] = '{8'h02, 8'h01, 8'h03, 8'h3C, 8'h01, 8'hFF, 1'b1, 1'b1};

    bus.rx = 1'b1;
    rst    = 1'b1;
    repeat (5) @(posedge clk);
    rst = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    check_regs("reset", 8'hFF, 8'd5, 8'd20, 1'b1);
    check("reset_cfg_pulses", cfg_cnt, 0);
    check("reset_err_pulses", err_cnt, 0);

    for (int v = 0; v < 11; v++) begin
      c0 = cfg_cnt;
      e0 = err_cnt;
      send_frame(vecs[v].cmd, vecs[v].data, vecs[v].csum);
      repeat (30) @(posedge clk);
      #1;
      check($sformatf("vec%0d_cfg_valid", v), cfg_cnt - c0, vecs[v].ok ? 1 : 0);
      check($sformatf("vec%0d_frame_err", v), err_cnt - e0, vecs[v].ok ? 0 : 1);
      check_regs($sformatf("vec%0d", v), vecs[v].pat, vecs[v].on_t, vecs[v].off_t, vecs[v].en);
      if (vecs[v].ok) check($sformatf("vec%0d_pattern_at_pulse", v), int'(snap_pat), int'(vecs[v].pat));
    end

    // Timeout after an incomplete frame.
    e0 = err_cnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    k = 0;
    found = 1'b0;
    while (k < FT + 40 && !found) begin
      @(posedge clk);
      k++;
      if (err_cnt != e0) found = 1'b1;
    end
    check("timeout_fired", int'(found), 1);
    check("timeout_not_early", int'(k >= FT - 40), 1);
    check("timeout_single_err", err_cnt - e0, 1);
    c0 = cfg_cnt;
    e0 = err_cnt;
    send_frame(8'h01, 8'h0F, 8'h0E);
    repeat (30) @(posedge clk);
    #1;
    check("after_timeout_pattern", int'(bus.pattern), 8'h0F);
    check("after_timeout_cfg", cfg_cnt - c0, 1);
    check("after_timeout_err", err_cnt - e0, 0);

    // Bad stop bit mid-frame, then the rest of that frame must be ignored.
    c0 = cfg_cnt;
    e0 = err_cnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b0);
    repeat (40) @(posedge clk);
    check("stop_err", err_cnt - e0, 1);
    send_byte(8'h3C, 1'b1);
    send_byte(8'h3D, 1'b1);
    repeat (30) @(posedge clk);
    check("stop_err_resync_err", err_cnt - e0, 1);
    check("stop_err_resync_cfg", cfg_cnt - c0, 0);
    send_frame(8'h01, 8'h5A, 8'h5B);
    repeat (30) @(posedge clk);
    #1;
    check("after_stop_err_pattern", int'(bus.pattern), 8'h5A);
    check("after_stop_err_errs", err_cnt - e0, 1);

    // Short low glitch inside a frame must not produce a byte.
    c0 = cfg_cnt;
    e0 = err_cnt;
    send_byte(8'hA5, 1'b1);
    bus.rx = 1'b0;
    repeat (CPB / 4) @(posedge clk);
    bus.rx = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    send_byte(8'h01, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h32, 1'b1);
    repeat (30) @(posedge clk);
    #1;
    check("glitch_pattern", int'(bus.pattern), 8'h33);
    check("glitch_err", err_cnt - e0, 0);
    check("glitch_cfg", cfg_cnt - c0, 1);

    // Reset in the middle of a frame and a byte.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    bus.rx = 1'b0;
    repeat (40) @(posedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_regs("midrst", 8'hFF, 8'd5, 8'd20, 1'b1);
    check("midrst_cfg_low", int'(bus.cfg_valid), 0);
    check("midrst_err_low", int'(bus.frame_err), 0);
    bus.rx = 1'b1;
    repeat (2) @(posedge clk);
    rst = 1'b0;
    c0 = cfg_cnt;
    e0 = err_cnt;
    send_byte(8'h22, 1'b1);
    send_byte(8'h23, 1'b1);
    repeat (30) @(posedge clk);
    #1;
    check("postrst_cfg", cfg_cnt - c0, 0);
    check("postrst_err", err_cnt - e0, 0);
    check("postrst_pattern", int'(bus.pattern), 8'hFF);

    check("never_both_pulses", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
